bcd_chain_counter: RTL and testbench



---
 rtl/bcd_chain_counter_if.sv | 28 ++
 rtl/bcd_chain_counter.sv | 71 +++++++
 tb/tb_bcd_chain_counter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bcd_chain_counter_if.sv
// Signal bundle for one bcd_chain_counter: the count controls in and the
// count value and status flags out.
interface bcd_chain_counter_if #(
  parameter int DIGITS = 4
);
  // cin/cout are level-qualified enables, not a valid/ready handshake. A
  // count happens on every rising edge where cin is high. cout is high in
  // the same cycle when that count leaves the chain from its terminal state,
  // so the next chain counts on the same edge.
  logic                  cin;
  logic                  dn;
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic [4*DIGITS-1:0]   q;
  logic                  cout;
  logic                  zero;
  logic                  ovf;

  modport master (
    output cin, dn, load, din,
    input  q, cout, zero, ovf
  );

  modport slave (
    input  cin, dn, load, din,
    output q, cout, zero, ovf
  );
endinterface

// File: rtl/bcd_chain_counter.sv
// Cascaded multi-digit modulo counter with up/down counting, clamped load,
// wrap or saturate behaviour at the terminal count, and a sticky overflow flag.
module bcd_chain_counter #(
  parameter int          DIGITS = 4,
  parameter logic [31:0] MAXVEC = 32'h0000_5959,
  parameter int          WRAP   = 1
) (
  input  logic                clk,
  input  logic                clr,
  bcd_chain_counter_if.slave  bus
);

  logic [DIGITS-1:0][3:0] r_q;
  logic                   r_ovf;

  logic [DIGITS-1:0][3:0] w_nxt_q;
  logic [DIGITS-1:0][3:0] w_load_q;
  logic [3:0]             w_max_d;
  logic                   w_carry;
  logic                   w_terminal;
  logic                   w_count;

  // w_carry ripples from digit 0 upward. It stays high only while every lower
  // digit sits at its terminal value for the current direction. Once it has
  // passed all digits, it is the chain-wide terminal condition.
  always_comb begin
    w_nxt_q  = r_q;
    w_load_q = '0;
    w_carry  = 1'b1;
    w_max_d  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_max_d     = MAXVEC[4*i +: 4];
      w_load_q[i] = (bus.din[4*i +: 4] > w_max_d) ? w_max_d : bus.din[4*i +: 4];
      if (w_carry) begin
        if (bus.dn) begin
          w_nxt_q[i] = (r_q[i] == 4'd0) ? w_max_d : r_q[i] - 4'd1;
        end else begin
          w_nxt_q[i] = (r_q[i] == w_max_d) ? 4'd0 : r_q[i] + 4'd1;
        end
      end
      w_carry = w_carry & (bus.dn ? (r_q[i] == 4'd0) : (r_q[i] == w_max_d));
    end
    w_terminal = w_carry;
  end

  assign w_count = bus.cin & ~bus.load & ~clr;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (bus.load) begin
      r_q   <= w_load_q;
      r_ovf <= 1'b0;
    end else if (bus.cin) begin
      if (w_terminal) begin
        r_ovf <= 1'b1;
      end
      // Saturating chains freeze at the terminal value instead of wrapping.
      if (!(w_terminal && (WRAP == 0))) begin
        r_q <= w_nxt_q;
      end
    end
  end

  assign bus.q    = r_q;
  assign bus.cout = w_count & w_terminal;
  assign bus.zero = (r_q == '0);
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Directed bench for bcd_chain_counter: wrap chain, saturating chain, and a
// two-chain ss.hh -> mm:ss cascade, with hand-computed expected values.
module tb_bcd_chain_counter;

  logic clk;
  logic clr_main;
  logic clr_sat;
  logic clr_casc;

  int n_checks = 0;
  int n_errors = 0;

  bcd_chain_counter_if #(.DIGITS(4)) if_main ();
  bcd_chain_counter_if #(.DIGITS(4)) if_sat ();
  bcd_chain_counter_if #(.DIGITS(4)) if_lo ();
  bcd_chain_counter_if #(.DIGITS(4)) if_hi ();

  bcd_chain_counter #(.DIGITS(4), .MAXVEC(32'h0000_5959), .WRAP(1)) u_main (
    .clk(clk), .clr(clr_main), .bus(if_main.slave)
  );

  bcd_chain_counter #(.DIGITS(4), .MAXVEC(32'h0000_5959), .WRAP(0)) u_sat (
    .clk(clk), .clr(clr_sat), .bus(if_sat.slave)
  );

  // Lower chain is ss.hh (seconds 0-59, hundredths 0-99); its cout drives
  // the mm:ss chain above it.
  bcd_chain_counter #(.DIGITS(4), .MAXVEC(32'h0000_5999), .WRAP(1)) u_lo (
    .clk(clk), .clr(clr_casc), .bus(if_lo.slave)
  );

  bcd_chain_counter #(.DIGITS(4), .MAXVEC(32'h0000_5959), .WRAP(1)) u_hi (
    .clk(clk), .clr(clr_casc), .bus(if_hi.slave)
  );

  assign if_hi.cin = if_lo.cout;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clr_main = 1'b1; clr_sat = 1'b1; clr_casc = 1'b1;
    if_main.cin = 1'b1; if_main.dn = 1'b0; if_main.load = 1'b0; if_main.din = '0;
    if_sat.cin  = 1'b0; if_sat.dn  = 1'b0; if_sat.load  = 1'b0; if_sat.din  = '0;
    if_lo.cin   = 1'b0; if_lo.dn   = 1'b0; if_lo.load   = 1'b0; if_lo.din   = '0;
    if_hi.dn    = 1'b0; if_hi.load = 1'b0; if_hi.din    = '0;
    step();
    step();

    // reset state; cout forced low while clr is high even with cin high
    chk("rst_q",    {16'h0, if_main.q}, 32'h0);
    chk("rst_zero", {31'h0, if_main.zero}, 32'h1);
    chk("rst_ovf",  {31'h0, if_main.ovf}, 32'h0);
    chk("rst_cout", {31'h0, if_main.cout}, 32'h0);

    // up mm:ss: 3599 counts reach 59:59
    clr_main = 1'b0;
    if_main.cin = 1'b1;
    for (int i = 0; i < 3599; i++) step();
    chk("up_q_5959",   {16'h0, if_main.q}, 32'h5959);
    chk("up_cout_term", {31'h0, if_main.cout}, 32'h1);
    chk("up_ovf_pre",  {31'h0, if_main.ovf}, 32'h0);
    chk("up_zero_pre", {31'h0, if_main.zero}, 32'h0);
    step();
    chk("up_wrap_q",   {16'h0, if_main.q}, 32'h0);
    chk("up_wrap_ovf", {31'h0, if_main.ovf}, 32'h1);
    chk("up_wrap_zero", {31'h0, if_main.zero}, 32'h1);

    // carry ripple across the seconds/minutes boundary
    if_main.cin = 1'b0; if_main.load = 1'b1; if_main.din = 16'h0959;
    step();
    if_main.load = 1'b0;
    chk("load_0959",   {16'h0, if_main.q}, 32'h0959);
    chk("load_clr_ovf", {31'h0, if_main.ovf}, 32'h0);
    if_main.cin = 1'b1;
    #1;
    chk("ripple_cout0", {31'h0, if_main.cout}, 32'h0);
    step();
    chk("ripple_1000", {16'h0, if_main.q}, 32'h1000);
    if_main.cin = 1'b0; if_main.load = 1'b1; if_main.din = 16'h5909;
    step();
    if_main.load = 1'b0; if_main.cin = 1'b1;
    step();
    chk("ripple_5910", {16'h0, if_main.q}, 32'h5910);

    // down counting with borrow, then wrap from zero
    if_main.cin = 1'b0; if_main.load = 1'b1; if_main.din = 16'h0100;
    step();
    if_main.load = 1'b0; if_main.dn = 1'b1; if_main.cin = 1'b1;
    step();
    chk("down_0059", {16'h0, if_main.q}, 32'h0059);
    if_main.cin = 1'b0; if_main.load = 1'b1; if_main.din = 16'h0000;
    step();
    if_main.load = 1'b0; if_main.cin = 1'b1;
    #1;
    chk("down_cout_term", {31'h0, if_main.cout}, 32'h1);
    step();
    chk("down_wrap_q",   {16'h0, if_main.q}, 32'h5959);
    chk("down_wrap_ovf", {31'h0, if_main.ovf}, 32'h1);

    // load beats cin: clamp and ovf clear; cout masked by load at terminal
    if_main.dn = 1'b0; if_main.load = 1'b1; if_main.din = 16'hFFFF; if_main.cin = 1'b1;
    #1;
    chk("load_masks_cout", {31'h0, if_main.cout}, 32'h0);
    step();
    chk("clamp_ffff", {16'h0, if_main.q}, 32'h5959);
    chk("clamp_ovf",  {31'h0, if_main.ovf}, 32'h0);
    if_main.din = 16'h7A3B;
    step();
    chk("clamp_7a3b", {16'h0, if_main.q}, 32'h5939);
    clr_main = 1'b1;
    step();
    chk("clr_beats_load", {16'h0, if_main.q}, 32'h0);
    clr_main = 1'b0; if_main.load = 1'b0; if_main.cin = 1'b0;

    // saturating chain
    clr_sat = 1'b0; if_sat.load = 1'b1; if_sat.din = 16'h5958;
    step();
    if_sat.load = 1'b0; if_sat.cin = 1'b1;
    step();
    chk("sat_p1_q",   {16'h0, if_sat.q}, 32'h5959);
    chk("sat_p1_ovf", {31'h0, if_sat.ovf}, 32'h0);
    chk("sat_cout",   {31'h0, if_sat.cout}, 32'h1);
    step();
    chk("sat_p2_q",   {16'h0, if_sat.q}, 32'h5959);
    chk("sat_p2_ovf", {31'h0, if_sat.ovf}, 32'h1);
    step();
    chk("sat_p3_q",   {16'h0, if_sat.q}, 32'h5959);
    chk("sat_p3_cout", {31'h0, if_sat.cout}, 32'h1);
    if_sat.cin = 1'b0; if_sat.load = 1'b1; if_sat.din = 16'h0000;
    step();
    chk("sat_load_ovf", {31'h0, if_sat.ovf}, 32'h0);
    if_sat.load = 1'b0; if_sat.dn = 1'b1; if_sat.cin = 1'b1;
    step();
    chk("sat_dn_q",   {16'h0, if_sat.q}, 32'h0);
    chk("sat_dn_ovf", {31'h0, if_sat.ovf}, 32'h1);
    if_sat.cin = 1'b0;

    // cascade: 6000 hundredths = one minute
    clr_casc = 1'b0; if_lo.cin = 1'b1;
    for (int i = 0; i < 5999; i++) step();
    chk("casc_lo_5999", {16'h0, if_lo.q}, 32'h5999);
    chk("casc_lo_cout", {31'h0, if_lo.cout}, 32'h1);
    chk("casc_hi_pre",  {16'h0, if_hi.q}, 32'h0);
    step();
    if_lo.cin = 1'b0;
    #1;
    chk("casc_lo_q", {16'h0, if_lo.q}, 32'h0);
    chk("casc_hi_q", {16'h0, if_hi.q}, 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
